// File: rtl/l2_match_collector.sv
// Match collector behind the Cuckoo level-2 lookup: tags each byte with its payload offset,
// re-aligns compare results with that tag and queues hit records in a dual-write FIFO.
module l2_match_collector #(
    parameter int LAT   = 4,
    parameter int OFF_W = 11,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    pkt_start,
    input  logic [1:0]              compare_out,
    input  logic [1:0]              suffix,
    input  logic [1:0]              compare_out_nocase,
    input  logic [1:0]              suffix_nocase,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OFF_W+4:0]        m_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = OFF_W + 5;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [OFF_W-1:0] r_off;
    logic [OFF_W-1:0] w_tag;
    logic             r_dv_p   [LAT];
    logic [OFF_W-1:0] r_tag_p  [LAT];

    // Byte stage: tag assignment and the alignment delay line
    assign w_tag = pkt_start ? '0 : r_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off <= '0;
        end else if (enable) begin
            r_off <= w_tag + OFF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) r_dv_p[i] <= 1'b0;
        end else begin
            r_dv_p[0] <= enable;
            for (int i = 1; i < LAT; i++) r_dv_p[i] <= r_dv_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_tag_p[0] <= w_tag;
        for (int i = 1; i < LAT; i++) r_tag_p[i] <= r_tag_p[i-1];
    end

    // Result stage: hit detection and FIFO write/read control
    logic             w_dv, w_hit_c, w_hit_n, w_sp1, w_sp2, w_we0, w_we1, w_pop;
    logic [REC_W-1:0] w_rec_c, w_rec_n, w_rec0, w_head_nxt;
    logic [1:0]       w_nhit, w_nstore, w_ndrop;
    logic [PTR_W-1:0] r_wptr, r_rptr, w_wptr1, w_rptr_nxt;
    logic [LVL_W-1:0] r_level, w_level_nxt;
    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_mdata;
    logic [15:0]      r_drop;

    assign w_dv    = r_dv_p[LAT-1];
    assign w_hit_c = w_dv & (|compare_out);
    assign w_hit_n = w_dv & (|compare_out_nocase);
    assign w_rec_c = {1'b0, compare_out, suffix, r_tag_p[LAT-1]};
    assign w_rec_n = {1'b1, compare_out_nocase, suffix_nocase, r_tag_p[LAT-1]};
    // A lone nocase hit takes the first write slot
    assign w_rec0  = w_hit_c ? w_rec_c : w_rec_n;

    assign w_sp1    = r_level < LVL_W'(DEPTH);
    assign w_sp2    = r_level < LVL_W'(DEPTH - 1);
    assign w_we0    = (w_hit_c | w_hit_n) & w_sp1;
    assign w_we1    = w_hit_c & w_hit_n & w_sp2;
    assign w_nhit   = {1'b0, w_hit_c} + {1'b0, w_hit_n};
    assign w_nstore = {1'b0, w_we0} + {1'b0, w_we1};
    assign w_ndrop  = w_nhit - w_nstore;

    assign w_pop       = (r_level != '0) & m_ready;
    assign w_wptr1     = r_wptr + PTR_W'(1);
    assign w_rptr_nxt  = r_rptr + PTR_W'(w_pop);
    assign w_level_nxt = r_level + LVL_W'(w_we0) + LVL_W'(w_we1) - LVL_W'(w_pop);

    // Next head may be a record being written this very cycle
    always_comb begin
        w_head_nxt = r_mem[w_rptr_nxt];
        if (w_we0 && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = w_rec0;
        end else if (w_we1 && (w_wptr1 == w_rptr_nxt)) begin
            w_head_nxt = w_rec_n;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we0) r_mem[r_wptr]  <= w_rec0;
        if (w_we1) r_mem[w_wptr1] <= w_rec_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_drop  <= '0;
            r_mdata <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_we0) + PTR_W'(w_we1);
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_drop  <= sat_add(r_drop, w_ndrop);
            if (w_level_nxt != '0) r_mdata <= w_head_nxt;
        end
    end

    assign m_valid    = (r_level != '0);
    assign m_data     = r_mdata;
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop;
endmodule
